// File: rtl/npc_pc_reg_if.sv
// rtl/npc_pc_reg_if.sv - decode-to-fetch redirect bus for the fetch PC register
interface npc_pc_reg_if;
   logic        stall_f;
   logic        br_taken;
   logic [31:0] pc_d;
   logic [15:0] imm16;
   logic        jump_en;
   logic [25:0] jump_idx;
   logic        jr_en;
   logic [31:0] jr_target;
   logic [31:0] pc_f;
   logic [31:0] link_pc;
   logic        redirect;
   logic        addr_err;
   logic        req_drop;

   modport master (
      output stall_f, br_taken, pc_d, imm16, jump_en, jump_idx, jr_en, jr_target,
      input  pc_f, link_pc, redirect, addr_err, req_drop
   );

   modport slave (
      input  stall_f, br_taken, pc_d, imm16, jump_en, jump_idx, jr_en, jr_target,
      output pc_f, link_pc, redirect, addr_err, req_drop
   );
endinterface

// File: rtl/npc_pc_reg.sv
// rtl/npc_pc_reg.sv - fetch PC register with branch/jump/jr redirect and stall-time pending slot
module npc_pc_reg #(
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter bit          CHECK_ALIGN = 1'b1
) (
   input logic        clk,
   input logic        rst_n,
   npc_pc_reg_if.slave bus
);

   typedef enum logic {ST_RUN, ST_PEND} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q, pc_nxt;
   logic [31:0] pend_pc, pend_pc_nxt;
   logic        pend_err, pend_err_nxt;
   logic        redirect_q, redirect_nxt;
   logic        addr_err_q, addr_err_nxt;
   logic        req_drop_q, req_drop_nxt;

   logic        req;
   logic [31:0] pc_d_plus4;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] tgt;
   logic        tgt_err;

   assign req        = bus.jr_en | bus.jump_en | bus.br_taken;
   assign pc_d_plus4 = bus.pc_d + 32'd4;
   assign br_tgt     = pc_d_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
   assign j_tgt      = {pc_d_plus4[31:28], bus.jump_idx, 2'b00};

   // Priority jr > j > branch; only a jr target can be misaligned.
   always_comb begin
      tgt     = br_tgt;
      tgt_err = 1'b0;
      if (bus.jr_en) begin
         tgt     = bus.jr_target;
         tgt_err = CHECK_ALIGN && (bus.jr_target[1:0] != 2'b00);
      end else if (bus.jump_en) begin
         tgt = j_tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         pc_q       <= RESET_PC;
         pend_pc    <= 32'd0;
         pend_err   <= 1'b0;
         redirect_q <= 1'b0;
         addr_err_q <= 1'b0;
         req_drop_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc_q       <= pc_nxt;
         pend_pc    <= pend_pc_nxt;
         pend_err   <= pend_err_nxt;
         redirect_q <= redirect_nxt;
         addr_err_q <= addr_err_nxt;
         req_drop_q <= req_drop_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:  if (req && bus.stall_f) state_nxt = ST_PEND;
         ST_PEND: if (!bus.stall_f)       state_nxt = ST_RUN;
         default: state_nxt = ST_RUN;
      endcase
   end

   // A stalled request parks in pend_pc and is applied on the first unstalled cycle;
   // anything arriving while parked is discarded.
   always_comb begin
      pc_nxt       = pc_q;
      pend_pc_nxt  = pend_pc;
      pend_err_nxt = pend_err;
      redirect_nxt = 1'b0;
      addr_err_nxt = 1'b0;
      req_drop_nxt = 1'b0;
      case (state)
         ST_RUN: begin
            if (req && !bus.stall_f) begin
               pc_nxt       = tgt;
               redirect_nxt = 1'b1;
               addr_err_nxt = tgt_err;
            end else if (req) begin
               pend_pc_nxt  = tgt;
               pend_err_nxt = tgt_err;
            end else if (!bus.stall_f) begin
               pc_nxt = pc_q + 32'd4;
            end
         end
         ST_PEND: begin
            req_drop_nxt = req;
            if (!bus.stall_f) begin
               pc_nxt       = pend_pc;
               redirect_nxt = 1'b1;
               addr_err_nxt = pend_err;
            end
         end
         default: ;
      endcase
   end

   assign bus.pc_f     = pc_q;
   assign bus.link_pc  = bus.pc_d + 32'd8;
   assign bus.redirect = redirect_q;
   assign bus.addr_err = addr_err_q;
   assign bus.req_drop = req_drop_q;

endmodule
